// File: rtl/moore_pattern_detector.sv
// Parametrised Moore serial pattern detector with runtime overlap mode and a saturating match counter.
// Latency: detected/match_cnt update on the enabled edge that samples the last pattern bit; en=0 freezes history and state.
module moore_pattern_detector #(
   parameter int                 PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PAT     = 4'b1011,
   parameter int                 CNT_W   = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         din,
   input  logic                         overlap,
   input  logic                         cnt_clr,
   output logic                         detected,
   output logic [CNT_W-1:0]             match_cnt,
   output logic [$clog2(PAT_LEN+1)-1:0] fill
);

   localparam int                FILL_W    = $clog2(PAT_LEN+1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   typedef enum logic {SEARCH = 1'b0, DETECT = 1'b1} state_t;

   state_t             state;
   logic [PAT_LEN-1:0] sr;
   logic [PAT_LEN-1:0] nsr;
   logic [FILL_W-1:0]  nfill;
   logic               hit;

   always_comb begin
      nsr   = {sr[PAT_LEN-2:0], din};
      nfill = (fill == FILL_FULL) ? FILL_FULL : fill + 1'b1;
      hit   = (nfill == FILL_FULL) && (nsr == PAT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= SEARCH;
         sr        <= '0;
         fill      <= '0;
         match_cnt <= '0;
      end else begin
         if (en) begin
            state <= hit ? DETECT : SEARCH;
            // Non-overlapping mode discards history so the next match needs PAT_LEN fresh bits
            if (hit && !overlap) begin
               sr   <= '0;
               fill <= '0;
            end else begin
               sr   <= nsr;
               fill <= nfill;
            end
         end
         if (cnt_clr)
            match_cnt <= '0;
         else if (en && hit && (match_cnt != CNT_MAX))
            match_cnt <= match_cnt + 1'b1;
      end
   end

   assign detected = (state == DETECT);

endmodule

// File: tb/tb_moore_pattern_detector.sv
// Scoreboard bench: three detector configurations share one stimulus stream and are checked against a reference model.
module tb_moore_pattern_detector;

   logic       clk = 1'b0;
   logic       rst, en, din, overlap, cnt_clr;
   logic       det0, det1, det2;
   logic [7:0] cnt0, cnt1;
   logic [1:0] cnt2;
   logic [2:0] fill0, fill1, fill2;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int id;
      bit det;
      int cnt;
      int fill;
   } exp_t;

   exp_t sb_q[$];

   bit [3:0] m_sr[3];
   int       m_fill[3];
   bit       m_det[3];
   int       m_cnt[3];
   bit [3:0] m_pat[3] = '{4'b1011, 4'b1111, 4'b1011};
   int       m_max[3] = '{255, 255, 3};

   always #5 clk = ~clk;

   moore_pattern_detector dut0 (
      .clk(clk), .rst(rst), .en(en), .din(din), .overlap(overlap), .cnt_clr(cnt_clr),
      .detected(det0), .match_cnt(cnt0), .fill(fill0)
   );

   moore_pattern_detector #(.PAT_LEN(4), .PAT(4'b1111), .CNT_W(8)) dut1 (
      .clk(clk), .rst(rst), .en(en), .din(din), .overlap(overlap), .cnt_clr(cnt_clr),
      .detected(det1), .match_cnt(cnt1), .fill(fill1)
   );

   moore_pattern_detector #(.PAT_LEN(4), .PAT(4'b1011), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .en(en), .din(din), .overlap(overlap), .cnt_clr(cnt_clr),
      .detected(det2), .match_cnt(cnt2), .fill(fill2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_sr[k]   = '0;
         m_fill[k] = 0;
         m_det[k]  = 1'b0;
         m_cnt[k]  = 0;
      end
   endtask

   task automatic model_step(input int k, input bit e, input bit d, input bit ov, input bit clr);
      bit [3:0] nsr;
      int       nf;
      bit       hit;
      hit = 1'b0;
      if (e) begin
         nsr = {m_sr[k][2:0], d};
         nf  = (m_fill[k] < 4) ? m_fill[k] + 1 : 4;
         hit = (nf == 4) && (nsr == m_pat[k]);
         m_det[k] = hit;
         if (hit && !ov) begin
            m_sr[k]   = '0;
            m_fill[k] = 0;
         end else begin
            m_sr[k]   = nsr;
            m_fill[k] = nf;
         end
      end
      if (clr)
         m_cnt[k] = 0;
      else if (hit && m_cnt[k] < m_max[k])
         m_cnt[k]++;
   endtask

   task automatic compare_one(input exp_t x);
      logic [31:0] od, oc, of;
      case (x.id)
         0:       begin od = 32'(det0); oc = 32'(cnt0); of = 32'(fill0); end
         1:       begin od = 32'(det1); oc = 32'(cnt1); of = 32'(fill1); end
         default: begin od = 32'(det2); oc = 32'(cnt2); of = 32'(fill2); end
      endcase
      check($sformatf("d%0d_detected", x.id), od, 32'(x.det));
      check($sformatf("d%0d_match_cnt", x.id), oc, x.cnt);
      check($sformatf("d%0d_fill", x.id), of, x.fill);
   endtask

   task automatic cycle(input bit e, input bit d, input bit ov, input bit clr);
      @(negedge clk);
      en = e; din = d; overlap = ov; cnt_clr = clr;
      for (int k = 0; k < 3; k++) begin
         model_step(k, e, d, ov, clr);
         sb_q.push_back('{k, m_det[k], m_cnt[k], m_fill[k]});
      end
      @(posedge clk);
      #1;
      while (sb_q.size() > 0) compare_one(sb_q.pop_front());
   endtask

   task automatic feed(input bit [15:0] bits, input int n, input bit ov);
      for (int i = 0; i < n; i++) cycle(1'b1, bits[n-1-i], ov, 1'b0);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_det0"}, 32'(det0), 0);
      check({tag, "_cnt0"}, 32'(cnt0), 0);
      check({tag, "_fill0"}, 32'(fill0), 0);
      check({tag, "_det1"}, 32'(det1), 0);
      check({tag, "_cnt2"}, 32'(cnt2), 0);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst = 1'b1; en = 1'b0; cnt_clr = 1'b0;
      model_reset();
      #1;
      check_zero(tag);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int hi;
      rst = 1'b1; en = 1'b0; din = 1'b0; overlap = 1'b1; cnt_clr = 1'b0;
      model_reset();

      // Overlapping detection on 1011011: matches after bits 4 and 7
      do_reset("rst1");
      feed(16'b1011011, 7, 1'b1);
      check("s1_cnt", 32'(cnt0), 2);

      // Non-overlapping on the same stream: one match, three bits pending
      do_reset("rst2");
      feed(16'b1011011, 7, 1'b0);
      check("s2_cnt", 32'(cnt0), 1);
      check("s2_fill", 32'(fill0), 3);

      // en gap between bits 2 and 3
      do_reset("rst3");
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
         check("s3_gap_det", 32'(det0), 0);
      end
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      check("s3_det", 32'(det0), 1);
      check("s3_cnt", 32'(cnt0), 1);

      // Saturation of a 2-bit counter, then clear on a hit cycle
      do_reset("rst4");
      feed(16'b1011011011011011, 16, 1'b1);
      check("s4_sat", 32'(cnt2), 3);
      cycle(1'b1, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 1'b1);
      check("s4_clr_cnt", 32'(cnt2), 0);
      check("s4_clr_det", 32'(det2), 1);

      // Asynchronous reset asserted mid-cycle after a partial pattern
      do_reset("rst5");
      feed(16'b101, 3, 1'b1);
      #2;
      rst = 1'b1; en = 1'b0;
      model_reset();
      #1;
      check_zero("async");
      @(negedge clk);
      rst = 1'b0;
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      check("s5_det", 32'(det0), 0);
      check("s5_fill", 32'(fill0), 1);
      check("s5_cnt", 32'(cnt0), 0);

      // Pattern 1111 on six 1s, overlapping then non-overlapping
      do_reset("rst6");
      hi = 0;
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, 1'b1, 1'b1, 1'b0);
         if (det1) hi++;
      end
      check("s6_det_cycles", hi, 3);
      check("s6_cnt", 32'(cnt1), 3);

      do_reset("rst7");
      hi = 0;
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, 1'b1, 1'b0, 1'b0);
         if (det1) hi++;
      end
      check("s7_det_cycles", hi, 1);
      check("s7_cnt", 32'(cnt1), 1);

      // Random traffic: en, din, overlap and occasional clears
      do_reset("rst8");
      for (int i = 0; i < 400; i++)
         cycle(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
